fb_bank_arbiter: RTL and testbench

- Single-clock controller that owns one dual-bank framebuffer RAM: one bank is displayed, the other is written.
- Shares the RAM port between Game Boy pixel writes, which are buffered in a small FIFO, and DVI display reads, which take priority.
- Swaps the front bank only during display vblank, after the writer has finished a frame and all its queued writes are drained.
- Sits between the GB video path (writer, already in the gpuclk domain) and the DVI scan-out/colour path (reader).

---
 rtl/gb_video_pkg.sv | 19 +
 rtl/fb_bank_arbiter_if.sv | 40 ++++
 rtl/fb_wr_fifo.sv | 62 ++++++
 rtl/fb_bank_arbiter.sv | 120 ++++++++++++
 tb/tb_fb_bank_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_video_pkg.sv
// Shared Game Boy video types: screen geometry, framebuffer address width,
// pixel type and the bank-swap FSM state encoding.
// No logic; imported by the framebuffer arbiter files and its bench.
package gb_video_pkg;

  localparam int GB_W      = 160;
  localparam int GB_H      = 144;
  localparam int FB_ADDR_W = 15;

  // RGB555 plus one spare bit
  typedef logic [15:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } swap_state_e;

endpackage

// File: rtl/fb_bank_arbiter_if.sv
// Bundle of writer, display-reader and RAM-port signals of the framebuffer arbiter.
// slave: arbiter side. master: the surrounding video path / RAM side.
// Flow control is wr_valid/wr_ready on the writer; reads are fire-and-forget.
interface fb_bank_arbiter_if
  import gb_video_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              disp_vblank;
  logic              front_bank;
  logic [7:0]        frame_drops;
  logic [ADDR_W:0]   ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_frame_done, rd_req, rd_addr,
           disp_vblank, ram_dout,
    output wr_ready, rd_valid, rd_data, front_bank, frame_drops,
           ram_addr, ram_we, ram_din
  );

  modport master (
    output wr_valid, wr_addr, wr_data, wr_frame_done, rd_req, rd_addr,
           disp_vblank, ram_dout,
    input  wr_ready, rd_valid, rd_data, front_bank, frame_drops,
           ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering pixel writes in front of the RAM port.
// Latency: a pushed entry is visible on dout (empty low) the cycle after push.
// Backpressure: full/empty are registered; push when full / pop when empty are ignored.
module fb_wr_fifo
  import gb_video_pkg::*;
#(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             gpuclk,
  input  logic             gpuclk_rst_b,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;
  assign dout    = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

  // Next occupancy: a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  // Pointers, occupancy and flags registered from the next occupancy
  always_ff @(posedge gpuclk or negedge gpuclk_rst_b) begin
    if (!gpuclk_rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Entry storage; contents are don't-care until pushed
  always_ff @(posedge gpuclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/fb_bank_arbiter.sv
// Dual-bank framebuffer owner: display reads win the RAM port, queued pixel writes fill idle slots, bank swap in vblank.
// Latency: RAM op registered 1 cycle after request; rd_valid/rd_data RAM_LAT+1 cycles after rd_req.
// Backpressure: wr_ready drops when the write FIFO is full; continuous reads may stall the writer indefinitely.
module fb_bank_arbiter
  import gb_video_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  // counts from the request cycle and includes the ram_addr register; must be >= 1
  parameter int RAM_LAT    = 1
) (
  input  logic             gpuclk,
  input  logic             gpuclk_rst_b,
  fb_bank_arbiter_if.slave bus
);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic              ready_en_q;
  logic              fifo_full, fifo_empty, push, pop;
  logic [ENT_W-1:0]  fifo_dout;

  logic [ADDR_W:0]   ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;

  logic [RAM_LAT:0]  rd_pipe_q;
  logic [DATA_W-1:0] rd_data_q;

  swap_state_e       state_q, state_d;
  logic              front_q, front_d;
  logic [7:0]        drops_q, drops_d;

  // ready_en_q keeps wr_ready low through reset and releases it one clock later
  assign bus.wr_ready    = ready_en_q && !fifo_full;
  assign push            = bus.wr_valid && bus.wr_ready;
  assign pop             = !bus.rd_req && !fifo_empty;

  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_din     = ram_din_q;
  assign bus.rd_valid    = rd_pipe_q[RAM_LAT];
  assign bus.rd_data     = rd_data_q;
  assign bus.front_bank  = front_q;
  assign bus.frame_drops = drops_q;

  fb_wr_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .gpuclk       (gpuclk),
    .gpuclk_rst_b (gpuclk_rst_b),
    .push         (push),
    .pop          (pop),
    .din          ({bus.wr_addr, bus.wr_data}),
    .dout         (fifo_dout),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  // One RAM op per cycle: read to the front bank wins, else drain a write to the back bank
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    ram_din_d  = ram_din_q;
    if (bus.rd_req) begin
      ram_addr_d = {front_q, bus.rd_addr};
    end else if (!fifo_empty) begin
      ram_addr_d = {~front_q, fifo_dout[ENT_W-1:DATA_W]};
      ram_we_d   = 1'b1;
      ram_din_d  = fifo_dout[DATA_W-1:0];
    end
  end

  // Swap FSM: wait for a finished frame, a drained FIFO and vblank; count frames overtaken meanwhile
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    drops_d = drops_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.wr_frame_done) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (bus.wr_frame_done) begin
          if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
        end else if (fifo_empty && !push && bus.disp_vblank) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        front_d = ~front_q;
        state_d = bus.wr_frame_done ? ST_PENDING : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, RAM port, read-return pipe and status registers
  always_ff @(posedge gpuclk or negedge gpuclk_rst_b) begin
    if (!gpuclk_rst_b) begin
      ready_en_q <= 1'b0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
      rd_pipe_q  <= '0;
      rd_data_q  <= '0;
      state_q    <= ST_IDLE;
      front_q    <= 1'b0;
      drops_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_din_q  <= ram_din_d;
      rd_pipe_q  <= {rd_pipe_q[RAM_LAT-1:0], bus.rd_req};
      if (rd_pipe_q[RAM_LAT-1]) rd_data_q <= bus.ram_dout;
      state_q    <= state_d;
      front_q    <= front_d;
      drops_q    <= drops_d;
    end
  end
endmodule

// File: tb/tb_fb_bank_arbiter.sv
// Directed bench for fb_bank_arbiter with a behavioural RAM and a write log.
// Inputs change 1ns after the rising edge; outputs are checked at that point.
module tb_fb_bank_arbiter;
  import gb_video_pkg::*;

  logic clk = 1'b0;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  fb_bank_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  fb_bank_arbiter #(.ADDR_W(15), .DATA_W(16), .FIFO_DEPTH(4), .RAM_LAT(1)) dut (
    .gpuclk       (clk),
    .gpuclk_rst_b (rst_b),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read of the registered address, write on the clock edge.
  // Unwritten locations hold 0x1000+addr in bank 0 and 0x2000+addr in bank 1.
  pixel_t ram_mem [0:65535];
  bit     written [0:65535];
  assign bus.ram_dout = written[bus.ram_addr] ? ram_mem[bus.ram_addr]
                      : {(bus.ram_addr[15] ? 4'h2 : 4'h1), bus.ram_addr[11:0]};
  always @(posedge clk) begin
    if (bus.ram_we) begin
      ram_mem[bus.ram_addr] <= bus.ram_din;
      written[bus.ram_addr] <= 1'b1;
    end
  end

  // Every cycle carrying a RAM write strobe, logged as {addr, data}
  logic [31:0] wlog [$];
  always @(negedge clk) if (bus.ram_we) wlog.push_back({bus.ram_addr, bus.ram_din});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got %b want 0", bus.wr_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 16'h0) begin errors++; $display("FAIL rst_rd_data got %h want 0000", bus.rd_data); end
    checks++; if (bus.front_bank !== 1'b0) begin errors++; $display("FAIL rst_front got %b want 0", bus.front_bank); end
    checks++; if (bus.frame_drops !== 8'h0) begin errors++; $display("FAIL rst_drops got %0d want 0", bus.frame_drops); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b want 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 16'h0) begin errors++; $display("FAIL rst_ram_addr got %h want 0000", bus.ram_addr); end
    checks++; if (bus.ram_din !== 16'h0) begin errors++; $display("FAIL rst_ram_din got %h want 0000", bus.ram_din); end
    @(negedge clk) rst_b = 1'b1;
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rel_wr_ready got %b want 1", bus.wr_ready); end
    // queue three writes behind a stream of reads, then reset mid-cycle
    bus.rd_req = 1'b1; bus.rd_addr = 15'h0;
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 15'(i); bus.wr_data = 16'h0ABC + 16'(i);
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();
    #3 rst_b = 1'b0;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL mid_wr_ready got %b want 0", bus.wr_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 16'h0) begin errors++; $display("FAIL mid_rd_data got %h want 0000", bus.rd_data); end
    checks++; if (bus.ram_addr !== 16'h0) begin errors++; $display("FAIL mid_ram_addr got %h want 0000", bus.ram_addr); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL mid_ram_we got %b want 0", bus.ram_we); end
    bus.rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_b = 1'b1;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL rel2_wr_ready_early got %b want 0", bus.wr_ready); end
    wlog.delete();
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rel2_wr_ready got %b want 1", bus.wr_ready); end
    repeat (4) tick();
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL rst_stale_we got %0d writes want 0", wlog.size()); end
  endtask

  task automatic test_write_path();
    pixel_t tbl [4];
    tbl[0] = 16'h7FFF; tbl[1] = 16'h001F; tbl[2] = 16'h03E0; tbl[3] = 16'h7C00;
    wlog.delete();
    bus.rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 15'(i); bus.wr_data = tbl[i];
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL wp_ready[%0d] got %b want 1", i, bus.wr_ready); end
      tick();
    end
    bus.wr_valid = 1'b0;
    repeat (5) tick();
    checks++; if (wlog.size() != 4) begin errors++; $display("FAIL wp_count got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i] !== {16'h8000 + 16'(i), tbl[i]}) begin
        errors++; $display("FAIL wp_entry[%0d] got %h want %h", i, wlog[i], {16'h8000 + 16'(i), tbl[i]});
      end
    end
  endtask

  task automatic test_read_priority();
    int acc = 0;
    wlog.delete();
    for (int k = 0; k < 16; k++) begin
      bus.rd_req   = (k < 10);
      bus.rd_addr  = 15'(k);
      bus.wr_valid = (acc < 6);
      bus.wr_addr  = 15'h10 + 15'(acc);
      bus.wr_data  = 16'h4000 + 16'(acc);
      if (k >= 2 && k <= 11) begin
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL rp_rd_valid[%0d] got %b want 1", k, bus.rd_valid); end
        checks++; if (bus.rd_data !== 16'h1000 + 16'(k - 2)) begin errors++; $display("FAIL rp_rd_data[%0d] got %h want %h", k, bus.rd_data, 16'h1000 + 16'(k - 2)); end
      end else begin
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rp_rd_idle[%0d] got %b want 0", k, bus.rd_valid); end
      end
      if (k >= 1 && k <= 10) begin
        checks++; if (bus.ram_addr !== 16'(k - 1)) begin errors++; $display("FAIL rp_ram_addr[%0d] got %h want %h", k, bus.ram_addr, 16'(k - 1)); end
      end
      if (k == 10) begin
        checks++; if (acc != 4) begin errors++; $display("FAIL rp_accepted got %0d want 4", acc); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL rp_wr_ready got %b want 0", bus.wr_ready); end
      end
      if (k == 11) begin
        checks++; if (wlog.size() != 0) begin errors++; $display("FAIL rp_we_during_reads got %0d want 0", wlog.size()); end
      end
      if (bus.wr_valid && bus.wr_ready) acc++;
      tick();
    end
    bus.wr_valid = 1'b0; bus.rd_req = 1'b0;
    repeat (8) tick();
    checks++; if (wlog.size() != 6) begin errors++; $display("FAIL rp_drain_count got %0d want 6", wlog.size()); end
    for (int j = 0; j < 6 && j < wlog.size(); j++) begin
      checks++;
      if (wlog[j] !== {16'h8010 + 16'(j), 16'h4000 + 16'(j)}) begin
        errors++; $display("FAIL rp_drain[%0d] got %h want %h", j, wlog[j], {16'h8010 + 16'(j), 16'h4000 + 16'(j)});
      end
    end
  endtask

  task automatic test_deferred_swap();
    bus.disp_vblank = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 15'h3;
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 15'h20 + 15'(i); bus.wr_data = 16'h5A5A + 16'(i);
      tick();
    end
    bus.wr_valid = 1'b0; bus.wr_frame_done = 1'b1;
    tick();
    bus.wr_frame_done = 1'b0;
    repeat (3) tick();
    checks++; if (bus.front_bank !== 1'b0) begin errors++; $display("FAIL ds_no_vblank got %b want 0", bus.front_bank); end
    bus.disp_vblank = 1'b1;
    repeat (3) tick();
    checks++; if (bus.front_bank !== 1'b0) begin errors++; $display("FAIL ds_fifo_busy got %b want 0", bus.front_bank); end
    bus.disp_vblank = 1'b0; bus.rd_req = 1'b0;
    wlog.delete();
    repeat (5) tick();
    checks++; if (bus.front_bank !== 1'b0) begin errors++; $display("FAIL ds_drained_no_vblank got %b want 0", bus.front_bank); end
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL ds_drain_count got %0d want 2", wlog.size()); end
    else if (wlog[1] !== {16'h8021, 16'h5A5B}) begin errors++; $display("FAIL ds_drain_last got %h want 80215a5b", wlog[1]); end
    bus.disp_vblank = 1'b1;
    tick();
    checks++; if (bus.front_bank !== 1'b0) begin errors++; $display("FAIL ds_swap_cycle got %b want 0", bus.front_bank); end
    tick();
    checks++; if (bus.front_bank !== 1'b1) begin errors++; $display("FAIL ds_after_swap got %b want 1", bus.front_bank); end
    bus.disp_vblank = 1'b0;
  endtask

  task automatic test_drops();
    for (int i = 0; i < 3; i++) begin
      bus.wr_frame_done = 1'b1; tick();
      bus.wr_frame_done = 1'b0; tick();
    end
    checks++; if (bus.frame_drops !== 8'd2) begin errors++; $display("FAIL dr_count got %0d want 2", bus.frame_drops); end
    checks++; if (bus.front_bank !== 1'b1) begin errors++; $display("FAIL dr_no_swap got %b want 1", bus.front_bank); end
    bus.disp_vblank = 1'b1;
    repeat (2) tick();
    checks++; if (bus.front_bank !== 1'b0) begin errors++; $display("FAIL dr_swap got %b want 0", bus.front_bank); end
    repeat (4) tick();
    checks++; if (bus.front_bank !== 1'b0) begin errors++; $display("FAIL dr_single_swap got %b want 0", bus.front_bank); end
    bus.disp_vblank = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) begin
      bus.wr_frame_done = 1'b1;
      tick();
      if (i == 99) begin
        checks++; if (bus.frame_drops !== 8'd101) begin errors++; $display("FAIL dr_mid got %0d want 101", bus.frame_drops); end
      end
    end
    bus.wr_frame_done = 1'b0;
    tick();
    checks++; if (bus.frame_drops !== 8'd255) begin errors++; $display("FAIL dr_saturate got %0d want 255", bus.frame_drops); end
    bus.disp_vblank = 1'b1;
    repeat (2) tick();
    checks++; if (bus.front_bank !== 1'b1) begin errors++; $display("FAIL dr_sat_swap got %b want 1", bus.front_bank); end
    bus.disp_vblank = 1'b0;
    tick();
  endtask

  task automatic test_swap_edge();
    bus.disp_vblank = 1'b1; bus.wr_frame_done = 1'b1;
    tick();
    bus.wr_frame_done = 1'b0;
    tick();
    // now in the SWAP cycle: read and a new frame_done coincide
    bus.rd_req = 1'b1; bus.rd_addr = 15'h5; bus.wr_frame_done = 1'b1;
    checks++; if (bus.front_bank !== 1'b1) begin errors++; $display("FAIL se_in_swap got %b want 1", bus.front_bank); end
    tick();
    bus.wr_frame_done = 1'b0; bus.rd_addr = 15'h6;
    checks++; if (bus.ram_addr !== 16'h8005) begin errors++; $display("FAIL se_old_bank_addr got %h want 8005", bus.ram_addr); end
    checks++; if (bus.front_bank !== 1'b0) begin errors++; $display("FAIL se_toggled got %b want 0", bus.front_bank); end
    tick();
    bus.rd_req = 1'b0;
    checks++; if (bus.ram_addr !== 16'h0006) begin errors++; $display("FAIL se_new_bank_addr got %h want 0006", bus.ram_addr); end
    checks++; if (bus.rd_data !== 16'h2005) begin errors++; $display("FAIL se_old_bank_data got %h want 2005", bus.rd_data); end
    checks++; if (bus.front_bank !== 1'b0) begin errors++; $display("FAIL se_pending_hold got %b want 0", bus.front_bank); end
    tick();
    checks++; if (bus.rd_data !== 16'h1006) begin errors++; $display("FAIL se_new_bank_data got %h want 1006", bus.rd_data); end
    checks++; if (bus.front_bank !== 1'b1) begin errors++; $display("FAIL se_second_swap got %b want 1", bus.front_bank); end
    checks++; if (bus.frame_drops !== 8'd255) begin errors++; $display("FAIL se_drops got %0d want 255", bus.frame_drops); end
    bus.disp_vblank = 1'b0;
    tick();
  endtask

  initial begin
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_frame_done = 1'b0;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.disp_vblank = 1'b0;
    rst_b = 1'b1;
    #1 rst_b = 1'b0;
    test_reset();
    test_write_path();
    test_read_priority();
    test_deferred_swap();
    test_drops();
    test_swap_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
